// File: rtl/kf_au_pkg.sv
// Shared definitions for the Kalman-filter AU micro-sequencer: opcodes,
// y-select codes, sequencer states, instruction layout and watchdog limit.
package kf_au_pkg;

    localparam int AU_W    = 24;  // S9.14 sign-magnitude, bit 23 = sign
    localparam int AU_FRAC = 14;  // fraction bits, carried for reference only
    localparam int AU_PC_W = 6;   // 64-entry program memory

    localparam int NREG   = 16;
    localparam int REG_AW = 4;

    // Instruction word: {op, ysel, rd, ra, rb, rc, last, rsvd}
    localparam int INSTR_W   = 22;
    localparam int OP_LSB    = 20;
    localparam int YSEL_LSB  = 18;
    localparam int RD_LSB    = 14;
    localparam int RA_LSB    = 10;
    localparam int RB_LSB    = 6;
    localparam int RC_LSB    = 2;
    localparam int LAST_BIT  = 1;
    localparam int RSVD_BIT  = 0;

    // WAIT aborts once this many cycles pass without au_done
    localparam int WDOG_LIMIT = 64;
    localparam int WDOG_W     = 6;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MULT = 2'b10,
        OP_OP3  = 2'b11
    } au_op_e;

    typedef enum logic [1:0] {
        YSEL_0 = 2'b00,
        YSEL_1 = 2'b01,
        YSEL_2 = 2'b10,
        YSEL_3 = 2'b11
    } ysel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } state_e;

    // Field order matches the bit positions listed above (MSB first)
    typedef struct packed {
        logic [1:0]        op;
        logic [1:0]        ysel;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [REG_AW-1:0] rc;
        logic              last;
        logic              rsvd;
    } instr_t;

endpackage

// File: rtl/au_seq_regfile.sv
// 16 x W register file for the AU sequencer: one write port, three operand
// read ports and one host read port, all reads combinational.
module au_seq_regfile
    import kf_au_pkg::*;
#(
    parameter int W = AU_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [REG_AW-1:0] i_ra_addr,
    input  logic [REG_AW-1:0] i_rb_addr,
    input  logic [REG_AW-1:0] i_rc_addr,
    input  logic [REG_AW-1:0] i_host_addr,
    output logic [W-1:0]      o_ra_data,
    output logic [W-1:0]      o_rb_data,
    output logic [W-1:0]      o_rc_data,
    output logic [W-1:0]      o_host_data
);

    logic [W-1:0] r_mem [NREG];

    // Register array: cleared by reset, single write port
    // NOTE: the array is reset, so it maps to plain flops rather than a RAM macro;
    // acceptable here because the host relies on every register reading 0 after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data   = r_mem[i_ra_addr];
    assign o_rb_data   = r_mem[i_rb_addr];
    assign o_rc_data   = r_mem[i_rc_addr];
    assign o_host_data = r_mem[i_host_addr];

endmodule

// File: rtl/au_seq.sv
// Micro-sequencer for the shared S9.14 arithmetic unit: fetches an
// instruction, issues operands with a start pulse, waits for done and writes
// the result back into the internal register file.
// Build option: define AU_SEQ_WDOG_EN to add a 64-cycle WAIT watchdog.
module au_seq
    import kf_au_pkg::*;
#(
    parameter int W    = AU_W,
    parameter int PC_W = AU_PC_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_go,
    input  logic [PC_W-1:0]    i_start_pc,
    output logic [PC_W-1:0]    o_prog_addr,
    input  logic [INSTR_W-1:0] i_prog_data,
    output logic               o_au_start,
    output logic [W-1:0]       o_au_r,
    output logic [W-1:0]       o_au_s,
    output logic [W-1:0]       o_au_iimm,
    output logic [1:0]         o_au_op,
    output logic [1:0]         o_au_mul_y_sel,
    input  logic [W-1:0]       i_au_result,
    input  logic               i_au_done,
    input  logic               i_au_busy,
    input  logic               i_wr_en,
    input  logic [REG_AW-1:0]  i_wr_addr,
    input  logic [W-1:0]       i_wr_data,
    input  logic [REG_AW-1:0]  i_rd_addr,
    output logic [W-1:0]       o_rd_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    instr_t          r_instr;
    logic [W-1:0]    r_result;
    logic            r_done;
    logic            r_err;
`ifdef AU_SEQ_WDOG_EN
    logic [WDOG_W-1:0] r_wdog;
`endif

    instr_t            w_instr;
    logic              w_issue;
    logic              w_drive_ops;
    logic              w_pc_end;
    logic              w_we;
    logic [REG_AW-1:0] w_waddr;
    logic [W-1:0]      w_wdata;
    logic [W-1:0]      w_ra_data;
    logic [W-1:0]      w_rb_data;
    logic [W-1:0]      w_rc_data;
    logic              w_unused_rsvd;

    // Program data is valid during ISSUE; afterwards the captured copy is used
    assign w_instr       = (r_state == ST_ISSUE) ? instr_t'(i_prog_data) : r_instr;
    assign w_unused_rsvd = w_instr.rsvd;

    assign w_issue     = (r_state == ST_ISSUE) && !i_au_busy;
    assign w_drive_ops = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_pc_end    = (r_pc == {PC_W{1'b1}});

    // Sequencer write-back has the port in WRITE; the host only in IDLE
    assign w_we    = (r_state == ST_WRITE) || ((r_state == ST_IDLE) && i_wr_en);
    assign w_waddr = (r_state == ST_WRITE) ? r_instr.rd : i_wr_addr;
    assign w_wdata = (r_state == ST_WRITE) ? r_result : i_wr_data;

    au_seq_regfile #(.W(W)) u_regfile (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_ra_addr   (w_instr.ra),
        .i_rb_addr   (w_instr.rb),
        .i_rc_addr   (w_instr.rc),
        .i_host_addr (i_rd_addr),
        .o_ra_data   (w_ra_data),
        .o_rb_data   (w_rb_data),
        .o_rc_data   (w_rc_data),
        .o_host_data (o_rd_data)
    );

    assign o_prog_addr    = r_pc;
    assign o_au_start     = w_issue;
    assign o_au_r         = w_drive_ops ? w_ra_data  : '0;
    assign o_au_s         = w_drive_ops ? w_rb_data  : '0;
    assign o_au_iimm      = w_drive_ops ? w_rc_data  : '0;
    assign o_au_op        = w_drive_ops ? w_instr.op : '0;
    assign o_au_mul_y_sel = w_drive_ops ? w_instr.ysel : '0;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = r_done;
    assign o_err          = r_err;

    // Sequencer FSM: fetch, issue, wait for AU, write back, advance pc
    // NOTE: every register here is assigned with <= so all next-state values
    // are computed from the same pre-edge snapshot, regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_instr  <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef AU_SEQ_WDOG_EN
            r_wdog   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_go) begin
                        r_pc    <= i_start_pc;
                        r_err   <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_instr <= instr_t'(i_prog_data);
                    if (!i_au_busy) begin
                        r_state <= ST_WAIT;
`ifdef AU_SEQ_WDOG_EN
                        r_wdog  <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (i_au_done) begin
                        r_result <= i_au_result;
                        r_state  <= ST_WRITE;
                    end
`ifdef AU_SEQ_WDOG_EN
                    else if (r_wdog == WDOG_W'(WDOG_LIMIT - 1)) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
`endif
                end
                ST_WRITE: begin
                    if (r_instr.last || w_pc_end) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        if (!r_instr.last) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
